sram_sdp_be: RTL and testbench
==============================

Name: sram_sdp_be

Overview:
- Parametrised simple-dual-port SRAM: one write port and one read port, both on the same clock.
- Successor to the 16x4 single-port SRAM; generalised in width and depth.
- Adds per-lane byte-enable writes, a selectable read-during-write mode, an optional output pipeline register with a read-valid flag, and a post-reset memory-clear sweep.
- Used as the common buffer/scratchpad macro for FIFOs and register files in the memories library.

Parameters:
- DATA_WIDTH, 8, width of the data bus; must be a multiple of LANE_WIDTH.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words.
- LANE_WIDTH, 4, bits per write-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new (merged) data.
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- INIT_CLEAR, 1, 1 = zero every word after reset before accepting traffic; 0 = no sweep.

Ports:
- clk    in   1           clock; all logic on the rising edge
- rst_n  in   1           asynchronous active-low reset
- we     in   1           write request
- waddr  in   ADDR_WIDTH  write address
- wdata  in   DATA_WIDTH  write data
- wbe    in   NUM_LANES   lane enables; bit i covers wdata[i*LANE_WIDTH +: LANE_WIDTH]
- re     in   1           read request
- raddr  in   ADDR_WIDTH  read address
- q      out  DATA_WIDTH  read data
- q_valid out 1           one-cycle pulse: q holds data for an accepted read
- busy   out  1           high while the clear sweep runs; requests ignored

Behaviour:
- Reset (rst_n=0, asynchronous):
  - q=0, q_valid=0, pipeline valid bits=0, sweep counter=0.
  - busy=1 if INIT_CLEAR=1, else busy=0.
  - The array itself is not reset.
- FSM states (INIT_CLEAR=1):
  - INIT: writes 0 to address cnt each cycle, then cnt+1. At the edge that writes cnt=DEPTH-1, go to READY and set busy=0. busy is high for exactly DEPTH cycles after reset release.
  - READY: normal operation. Leaves READY only on reset.
- INIT_CLEAR=0: the FSM is always in READY.
- In INIT, we and re are ignored: no array write, no q_valid.
- Write:
  - Accepted at an edge when we=1 and busy=0.
  - For each lane i with wbe[i]=1, that lane of mem[waddr] takes wdata; lanes with wbe[i]=0 are unchanged.
  - wbe=0 makes the write a no-op.
- Read:
  - Accepted at edge N when re=1 and busy=0.
  - OUT_REG=0: q updated at edge N; q_valid=1 for the following cycle.
  - OUT_REG=1: q updated at edge N+1; q_valid=1 for the cycle after edge N+1.
  - Fully pipelined: one read per cycle. q holds its last value when no read is accepted.
- Same-address read and write in the same cycle:
  - RDW_MODE=0: q returns the pre-write word.
  - RDW_MODE=1: q returns the lane-merged word. Lanes with wbe=1 come from wdata; the other lanes come from the old word.
  - Different addresses: independent, no interaction.
- Address wrap: addresses are full-range, so no out-of-range case exists. The sweep counter is ADDR_WIDTH+1 bits wide to detect the end of the sweep.
- Reset asserted mid-operation: in-flight reads are dropped (q_valid=0 immediately). The sweep restarts from address 0 after release.
- Elaboration check: fatal error if DATA_WIDTH % LANE_WIDTH != 0.

Test Plan (defaults unless noted):
- Reset and clear sweep:
  - Stimulus: write garbage with INIT_CLEAR=0 elaboration variant, then the default build; release rst_n, hold we=re=1 during busy.
  - Response: busy=1 for exactly 16 cycles, then 0; no q_valid while busy. Reading addresses 0..15 afterwards returns 0x00.
- Lane write:
  - Stimulus: write 0xAB to addr 3 with wbe=2'b11, then write 0x5C to addr 3 with wbe=2'b01, then read addr 3.
  - Response: q=0xAC; q_valid pulses one cycle after the read edge.
- Back-to-back reads:
  - Stimulus: read addresses 1, 2, 3 on consecutive cycles.
  - Response: q_valid high for 3 consecutive cycles with data in order.
  - OUT_REG=1: the same sequence, shifted one cycle later.
- Read-during-write, old data:
  - Stimulus: RDW_MODE=0; addr 5 holds 0x12; same cycle: write 0xFF to addr 5 with wbe=2'b10, and read addr 5.
  - Response: q=0x12; a later read of addr 5 returns 0xF2.
- Read-during-write, new data:
  - Stimulus: RDW_MODE=1, same stimulus as above.
  - Response: q=0xF2.
- Reset mid-read:
  - Stimulus: OUT_REG=1; accept a read, then assert rst_n=0 before the data returns.
  - Response: q=0, q_valid stays 0; busy reasserts and the 16-cycle sweep repeats.

Source files
------------

// File: rtl/sram_sdp_be.sv
// Simple-dual-port SRAM with per-lane byte-enable writes, selectable
// read-during-write behaviour, optional output register and a post-reset
// clear sweep. One write port and one read port share a single clock.
module sram_sdp_be #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned LANE_WIDTH = 4,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               we,
    input  logic [ADDR_WIDTH-1:0]              waddr,
    input  logic [DATA_WIDTH-1:0]              wdata,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   wbe,
    input  logic                               re,
    input  logic [ADDR_WIDTH-1:0]              raddr,
    output logic [DATA_WIDTH-1:0]              q,
    output logic                               q_valid,
    output logic                               busy
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

    if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lane_width
        $fatal(1, "sram_sdp_be: DATA_WIDTH must be a multiple of LANE_WIDTH");
    end

    typedef enum logic {
        StInit,
        StReady
    } state_e;

    state_e                 state_q;
    logic [ADDR_WIDTH:0]    cnt_q;
    logic                   busy_q;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic                   wr_acc;
    logic                   rd_acc;
    logic                   mem_wen;
    logic [ADDR_WIDTH-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [NUM_LANES-1:0]   mem_wmask;
    logic [DATA_WIDTH-1:0]  rd_word;

    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic                   rd_valid_q;

    // Requests are only honoured once the clear sweep has finished.
    assign wr_acc = we & ~busy_q;
    assign rd_acc = re & ~busy_q;
    assign busy   = busy_q;

    // Sweep/ready control: busy drops at the edge that clears the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (INIT_CLEAR != 0) ? StInit : StReady;
            cnt_q   <= '0;
            busy_q  <= (INIT_CLEAR != 0);
        end else begin
            case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= StReady;
                        busy_q  <= 1'b0;
                    end
                end
                StReady: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= StReady;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Write-port source select: the sweep owns the port while it runs.
    always_comb begin
        mem_wen   = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        mem_wmask = wbe;
        if (state_q == StInit) begin
            mem_wen   = 1'b1;
            mem_waddr = cnt_q[ADDR_WIDTH-1:0];
            mem_wdata = '0;
            mem_wmask = '1;
        end else if (wr_acc) begin
            mem_wen = 1'b1;
        end
    end

    // Array write with per-lane masking; the array itself has no reset.
    always_ff @(posedge clk) begin
        if (mem_wen) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (mem_wmask[i]) begin
                    mem[mem_waddr][i*LANE_WIDTH +: LANE_WIDTH] <=
                        mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Read word, optionally forwarding enabled lanes of a same-address write.
    always_comb begin
        rd_word = mem[raddr];
        if ((RDW_MODE != 0) && wr_acc && (waddr == raddr)) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wbe[i]) begin
                    rd_word[i*LANE_WIDTH +: LANE_WIDTH] = wdata[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // First read stage: data holds its value when no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_data_q;
        logic                  out_valid_q;

        // Extra output stage adds one cycle of read latency.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= rd_valid_q;
                if (rd_valid_q) begin
                    out_data_q <= rd_data_q;
                end
            end
        end

        assign q       = out_data_q;
        assign q_valid = out_valid_q;
    end else begin : g_no_out_reg
        assign q       = rd_data_q;
        assign q_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sram_sdp_be.sv
// Directed bench for sram_sdp_be. Three builds share one stimulus stream:
// u_a default (old-data RDW, latency 1, sweep), u_b (new-data RDW, latency 2,
// sweep) and u_c (no sweep).
module tb_sram_sdp_be;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [1:0] wbe;
    logic       re;
    logic [3:0] raddr;

    logic [7:0] q_a, q_b, q_c;
    logic       qv_a, qv_b, qv_c;
    logic       busy_a, busy_b, busy_c;

    int n_checks = 0;
    int n_fail   = 0;

    sram_sdp_be #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .LANE_WIDTH(4),
        .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .q(q_a), .q_valid(qv_a), .busy(busy_a)
    );

    sram_sdp_be #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .LANE_WIDTH(4),
        .RDW_MODE(1), .OUT_REG(1), .INIT_CLEAR(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .q(q_b), .q_valid(qv_b), .busy(busy_b)
    );

    sram_sdp_be #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .LANE_WIDTH(4),
        .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(0)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .q(q_c), .q_valid(qv_c), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic [1:0] be);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        wbe   = be;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        we    = 1'b1;
        re    = 1'b1;
        waddr = 4'd0;
        raddr = 4'd0;
        wdata = 8'hA5;
        wbe   = 2'b11;
        #12;
        n_checks++;
        if ({qv_a, q_a, busy_a} !== {1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_a: got qv=%b q=%h busy=%b, expected qv=0 q=00 busy=1",
                     qv_a, q_a, busy_a);
        end
        n_checks++;
        if ({qv_b, q_b, busy_b} !== {1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_b: got qv=%b q=%h busy=%b, expected qv=0 q=00 busy=1",
                     qv_b, q_b, busy_b);
        end
        n_checks++;
        if ({qv_c, q_c, busy_c} !== {1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_c: got qv=%b q=%h busy=%b, expected qv=0 q=00 busy=0",
                     qv_c, q_c, busy_c);
        end
        tick();
        rst_n = 1'b1;
        // we=re=1 held throughout the sweep; the swept builds must ignore them.
        n = 0;
        while (busy_a && n < 40) begin
            tick();
            n++;
            n_checks++;
            if (qv_a !== 1'b0 || qv_b !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_no_valid: cycle %0d got qv_a=%b qv_b=%b, expected 0 0",
                         n, qv_a, qv_b);
            end
            if (n == 2) begin
                n_checks++;
                if ({qv_c, q_c, busy_c} !== {1'b1, 8'hA5, 1'b0}) begin
                    n_fail++;
                    $display("FAIL noclear_rw: got qv=%b q=%h busy=%b, expected qv=1 q=a5 busy=0",
                             qv_c, q_c, busy_c);
                end
            end
        end
        we = 1'b0;
        re = 1'b0;
        n_checks++;
        if (n != 16) begin
            n_fail++;
            $display("FAIL sweep_len_a: busy lasted %0d cycles, expected 16", n);
        end
        n_checks++;
        if (busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_end_b: got busy=%b, expected 0", busy_b);
        end
    endtask

    task automatic test_clear_readback();
        for (int i = 0; i < 16; i++) begin
            raddr = 4'(i);
            re    = 1'b1;
            tick();
            n_checks++;
            if ({qv_a, q_a} !== {1'b1, 8'h00}) begin
                n_fail++;
                $display("FAIL clear_a[%0d]: got qv=%b q=%h, expected qv=1 q=00", i, qv_a, q_a);
            end
            if (i > 0) begin
                n_checks++;
                if ({qv_b, q_b} !== {1'b1, 8'h00}) begin
                    n_fail++;
                    $display("FAIL clear_b[%0d]: got qv=%b q=%h, expected qv=1 q=00",
                             i - 1, qv_b, q_b);
                end
            end
        end
        re = 1'b0;
        tick();
        n_checks++;
        if ({qv_a, qv_b, q_b} !== {1'b0, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL clear_tail: got qv_a=%b qv_b=%b q_b=%h, expected 0 1 00",
                     qv_a, qv_b, q_b);
        end
    endtask

    task automatic test_lane_write();
        do_write(4'd3, 8'hAB, 2'b11);
        do_write(4'd3, 8'h5C, 2'b01);
        re    = 1'b1;
        raddr = 4'd3;
        tick();
        re = 1'b0;
        n_checks++;
        if ({qv_a, q_a} !== {1'b1, 8'hAC}) begin
            n_fail++;
            $display("FAIL lane_a: got qv=%b q=%h, expected qv=1 q=ac", qv_a, q_a);
        end
        n_checks++;
        if (qv_b !== 1'b0) begin
            n_fail++;
            $display("FAIL lane_b_early: got qv=%b, expected 0", qv_b);
        end
        tick();
        n_checks++;
        if ({qv_a, q_a} !== {1'b0, 8'hAC}) begin
            n_fail++;
            $display("FAIL lane_a_hold: got qv=%b q=%h, expected qv=0 q=ac", qv_a, q_a);
        end
        n_checks++;
        if ({qv_b, q_b} !== {1'b1, 8'hAC}) begin
            n_fail++;
            $display("FAIL lane_b: got qv=%b q=%h, expected qv=1 q=ac", qv_b, q_b);
        end
        tick();
        n_checks++;
        if (qv_b !== 1'b0) begin
            n_fail++;
            $display("FAIL lane_b_pulse: got qv=%b, expected 0", qv_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h00;
        exp_d[1] = 8'h11;
        exp_d[2] = 8'h22;
        exp_d[3] = 8'h33;
        do_write(4'd1, 8'h11, 2'b11);
        do_write(4'd2, 8'h22, 2'b11);
        do_write(4'd3, 8'h33, 2'b11);
        for (int i = 1; i <= 4; i++) begin
            re    = (i <= 3);
            raddr = 4'(i);
            tick();
            if (i <= 3) begin
                n_checks++;
                if ({qv_a, q_a} !== {1'b1, exp_d[i]}) begin
                    n_fail++;
                    $display("FAIL b2b_a[%0d]: got qv=%b q=%h, expected qv=1 q=%h",
                             i, qv_a, q_a, exp_d[i]);
                end
            end else begin
                n_checks++;
                if (qv_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_a_end: got qv=%b, expected 0", qv_a);
                end
            end
            if (i >= 2) begin
                n_checks++;
                if ({qv_b, q_b} !== {1'b1, exp_d[i-1]}) begin
                    n_fail++;
                    $display("FAIL b2b_b[%0d]: got qv=%b q=%h, expected qv=1 q=%h",
                             i - 1, qv_b, q_b, exp_d[i-1]);
                end
            end
        end
        re = 1'b0;
        tick();
        n_checks++;
        if (qv_b !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_b_end: got qv=%b, expected 0", qv_b);
        end
    endtask

    task automatic test_rdw();
        do_write(4'd5, 8'h12, 2'b11);
        we    = 1'b1;
        waddr = 4'd5;
        wdata = 8'hFF;
        wbe   = 2'b10;
        re    = 1'b1;
        raddr = 4'd5;
        tick();
        we = 1'b0;
        re = 1'b0;
        n_checks++;
        if ({qv_a, q_a} !== {1'b1, 8'h12}) begin
            n_fail++;
            $display("FAIL rdw_old: got qv=%b q=%h, expected qv=1 q=12", qv_a, q_a);
        end
        tick();
        n_checks++;
        if ({qv_b, q_b} !== {1'b1, 8'hF2}) begin
            n_fail++;
            $display("FAIL rdw_new: got qv=%b q=%h, expected qv=1 q=f2", qv_b, q_b);
        end
        re    = 1'b1;
        raddr = 4'd5;
        tick();
        re = 1'b0;
        n_checks++;
        if ({qv_a, q_a} !== {1'b1, 8'hF2}) begin
            n_fail++;
            $display("FAIL rdw_after_a: got qv=%b q=%h, expected qv=1 q=f2", qv_a, q_a);
        end
        tick();
        n_checks++;
        if ({qv_b, q_b} !== {1'b1, 8'hF2}) begin
            n_fail++;
            $display("FAIL rdw_after_b: got qv=%b q=%h, expected qv=1 q=f2", qv_b, q_b);
        end
    endtask

    task automatic test_reset_mid_read();
        int n;
        re    = 1'b1;
        raddr = 4'd1;
        tick();
        re = 1'b0;
        n_checks++;
        if (qv_b !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_pre: got qv_b=%b, expected 0", qv_b);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({qv_b, q_b, busy_b} !== {1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_b: got qv=%b q=%h busy=%b, expected qv=0 q=00 busy=1",
                     qv_b, q_b, busy_b);
        end
        n_checks++;
        if ({qv_a, q_a, busy_a} !== {1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_a: got qv=%b q=%h busy=%b, expected qv=0 q=00 busy=1",
                     qv_a, q_a, busy_a);
        end
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        while (busy_b && n < 40) begin
            tick();
            n++;
            n_checks++;
            if (qv_b !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_sweep_valid: cycle %0d got qv_b=%b, expected 0", n, qv_b);
            end
        end
        n_checks++;
        if (n != 16) begin
            n_fail++;
            $display("FAIL midrst_sweep_len: busy lasted %0d cycles, expected 16", n);
        end
        re    = 1'b1;
        raddr = 4'd5;
        tick();
        re = 1'b0;
        n_checks++;
        if ({qv_a, q_a} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL midrst_clear_a: got qv=%b q=%h, expected qv=1 q=00", qv_a, q_a);
        end
        tick();
        n_checks++;
        if ({qv_b, q_b} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL midrst_clear_b: got qv=%b q=%h, expected qv=1 q=00", qv_b, q_b);
        end
    endtask

    initial begin
        test_reset();
        test_clear_readback();
        test_lane_write();
        test_back_to_back();
        test_rdw();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
